// File: rtl/store_fence_ctrl.sv
// Store fence controller.
// Tracks granted-but-unacknowledged stores, throttles store issue at
// MAX_OUTSTANDING, and sequences a fence: stop granting, wait for the
// outstanding count to drain to zero, optionally request a data-cache
// flush, then pulse fence_done_o for one cycle.
//
// Handshake semantics: a store is transferred in a cycle where
// st_req_i && st_gnt_o; st_req_i is a request level and carries no
// commitment to hold, and st_gnt_o is combinational from it. st_ack_i
// is a one-cycle completion pulse for one outstanding store. fence_i is a
// pulse sampled only while idle. flush_req_o is a level held until the
// cycle in which flush_ack_i is seen high.
module store_fence_ctrl #(
    parameter int MAX_OUTSTANDING = 7,
    parameter bit FLUSH_ON_FENCE  = 1'b0,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             st_req_i,
    output logic             st_gnt_o,
    input  logic             st_ack_i,
    input  logic             fence_i,
    output logic             fence_busy_o,
    output logic             fence_done_o,
    output logic             flush_req_o,
    input  logic             flush_ack_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             underflow_o,
    output logic [1:0]       fence_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             underflow_q;
    logic             cnt_full;
    logic             cnt_zero;
    logic             ack_take;
    logic             ack_underflow;

    assign cnt_full = (cnt_q >= MAX_CNT);
    assign cnt_zero = (cnt_q == '0);

    // An acknowledge only retires a store when one is actually outstanding.
    assign ack_take      = st_ack_i && !cnt_zero;
    assign ack_underflow = st_ack_i && cnt_zero && !st_gnt_o;

    // Grant only while idle; a same-cycle ack frees a slot when full. Reset
    // gates the grant so nothing is issued while rst_ni is low.
    always_comb begin
        st_gnt_o = 1'b0;
        if (rst_ni && st_req_i && (state_q == IDLE) && (!cnt_full || st_ack_i)) begin
            st_gnt_o = 1'b1;
        end
    end

    // Next outstanding count: +1 on grant, -1 on a retiring ack.
    always_comb begin
        cnt_d = cnt_q;
        if (st_gnt_o && !ack_take) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!st_gnt_o && ack_take) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Outstanding count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underflow_q <= 1'b0;
        end else if (ack_underflow) begin
            underflow_q <= 1'b1;
        end
    end

    // Fence state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fence sequencing: drain on the registered count, then optional flush.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fence_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    state_d = FLUSH_ON_FENCE ? FLUSH : DONE;
                end
            end
            FLUSH: begin
                if (flush_ack_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fence_busy_o  = (state_q != IDLE);
    assign fence_done_o  = (state_q == DONE);
    assign flush_req_o   = (state_q == FLUSH);
    assign outstanding_o = cnt_q;
    assign underflow_o   = underflow_q;
    assign fence_state_o = state_q;

    // The count must stay within 0..MAX_OUTSTANDING.
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= MAX_CNT);

    // Completion is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fence_done_o |=> !fence_done_o);

    // No stores are issued while a fence is in progress.
    a_no_gnt_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fence_busy_o |-> !st_gnt_o);

    // A flush is only requested when the variant asks for one.
    a_flush_cfg: assert property (@(posedge clk_i) disable iff (!rst_ni)
        flush_req_o |-> FLUSH_ON_FENCE);

endmodule

// File: tb/tb_store_fence_ctrl.sv
// Bench for store_fence_ctrl: two instances (without and with flush) share
// one stimulus stream and are each compared every cycle against a
// behavioural model of the fence/count rules.
module tb_store_fence_ctrl;

    localparam int MAX = 7;
    localparam int CW  = $clog2(MAX + 1);

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic st_req    = 1'b0;
    logic st_ack    = 1'b0;
    logic fence     = 1'b0;
    logic flush_ack = 1'b0;

    logic [1:0]    gnt;
    logic [1:0]    busy;
    logic [1:0]    done;
    logic [1:0]    freq;
    logic [1:0]    under;
    logic [CW-1:0] outst [2];
    logic [1:0]    dbg_state [2];

    store_fence_ctrl #(.MAX_OUTSTANDING(MAX), .FLUSH_ON_FENCE(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .st_req_i(st_req), .st_gnt_o(gnt[0]),
        .st_ack_i(st_ack), .fence_i(fence), .fence_busy_o(busy[0]),
        .fence_done_o(done[0]), .flush_req_o(freq[0]), .flush_ack_i(flush_ack),
        .outstanding_o(outst[0]), .underflow_o(under[0]), .fence_state_o(dbg_state[0])
    );

    store_fence_ctrl #(.MAX_OUTSTANDING(MAX), .FLUSH_ON_FENCE(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .st_req_i(st_req), .st_gnt_o(gnt[1]),
        .st_ack_i(st_ack), .fence_i(fence), .fence_busy_o(busy[1]),
        .fence_done_o(done[1]), .flush_req_o(freq[1]), .flush_ack_i(flush_ack),
        .outstanding_o(outst[1]), .underflow_o(under[1]), .fence_state_o(dbg_state[1])
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_seen [2];

    // Expected fence-completion cycles, one queue per instance.
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    // Reference model: count, sticky error, and the fence lifecycle.
    int m_cnt      [2];
    bit m_under    [2];
    bit m_busy     [2];
    bit m_flushing [2];
    bit m_done     [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    function automatic bit exp_gnt(input int i);
        return rst_ni && st_req && !m_busy[i] && (m_cnt[i] < MAX || st_ack);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_under[i] = 0; m_busy[i] = 0;
            m_flushing[i] = 0; m_done[i] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic push_done(input int i);
        if (i == 0) exp_q0.push_back(cyc);
        else        exp_q1.push_back(cyc);
    endtask

    // Advance the model by one clock edge using the inputs held over it.
    task automatic model_update();
        bit g;
        bit take;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            g    = exp_gnt(i);
            take = st_ack && (m_cnt[i] > 0);
            if (st_ack && m_cnt[i] == 0 && !g) m_under[i] = 1;
            if (m_done[i]) begin
                m_done[i] = 0;
                m_busy[i] = 0;
            end else if (m_flushing[i]) begin
                if (flush_ack) begin
                    m_flushing[i] = 0;
                    m_done[i]     = 1;
                    push_done(i);
                end
            end else if (m_busy[i]) begin
                if (m_cnt[i] == 0) begin
                    if (i == 1) m_flushing[i] = 1;
                    else begin
                        m_done[i] = 1;
                        push_done(i);
                    end
                end
            end else if (fence) begin
                m_busy[i] = 1;
            end
            m_cnt[i] = m_cnt[i] + (g ? 1 : 0) - (take ? 1 : 0);
        end
    endtask

    task automatic check_all();
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("gnt%0d", i),   gnt[i],   exp_gnt(i));
            chk($sformatf("busy%0d", i),  busy[i],  m_busy[i]);
            chk($sformatf("flush%0d", i), freq[i],  m_flushing[i]);
            chk($sformatf("done%0d", i),  done[i],  m_done[i]);
            chk($sformatf("cnt%0d", i),   outst[i], m_cnt[i]);
            chk($sformatf("under%0d", i), under[i], m_under[i]);
            if (done[i] === 1'b1) begin
                done_seen[i]++;
                if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                    chk($sformatf("done_unexp%0d", i), 1, 0);
                end else begin
                    e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk($sformatf("done_cyc%0d", i), cyc, e);
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge with inputs already set.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Asynchronous reset in mid low phase, checked before any clock edge.
    task automatic apply_reset();
        logic saved_req;
        saved_req = st_req;
        st_req = 1'b1;
        #1 rst_ni = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_gnt%0d", i),   gnt[i],   0);
            chk($sformatf("rst_busy%0d", i),  busy[i],  0);
            chk($sformatf("rst_done%0d", i),  done[i],  0);
            chk($sformatf("rst_flush%0d", i), freq[i],  0);
            chk($sformatf("rst_cnt%0d", i),   outst[i], 0);
            chk($sformatf("rst_under%0d", i), under[i], 0);
        end
        @(posedge clk);
        @(negedge clk);
        #1 chk("rst_hold_gnt0", gnt[0], 0);
        rst_ni = 1'b1;
        st_req = saved_req;
    endtask

    task automatic idle_inputs();
        st_req = 0; st_ack = 0; fence = 0; flush_ack = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int seen0;
        int seen1;
        done_seen[0] = 0;
        done_seen[1] = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Fill to the limit, then an 8th request must be refused.
        st_req = 1;
        repeat (MAX) tick();
        chk("fill_cnt0", outst[0], 7);
        chk("fill_cnt1", outst[1], 7);
        #1 chk("fill_gnt8", gnt[0], 0);
        tick();

        // Request and acknowledge together at full: granted, count holds.
        st_ack = 1;
        #1 chk("full_ra_gnt", gnt[0], 1);
        tick();
        chk("full_ra_cnt", outst[0], 7);

        // Retire four stores to reach 3.
        st_req = 0;
        repeat (4) tick();
        st_ack = 0;
        chk("cnt3", outst[0], 3);

        // Fence with drain; requests held high must not be granted.
        seen0 = done_seen[0];
        seen1 = done_seen[1];
        fence = 1;
        tick();
        fence = 0;
        st_req = 1;
        repeat (3) begin
            tick();
            st_ack = 1;
            tick();
            st_ack = 0;
        end
        st_req = 0;
        repeat (4) tick();
        chk("drain_flush_wait", freq[1], 1);
        flush_ack = 1;
        tick();
        flush_ack = 0;
        repeat (3) tick();
        chk("drain_done_cnt0", done_seen[0] - seen0, 1);
        chk("drain_done_cnt1", done_seen[1] - seen1, 1);

        // Fence from empty: plain variant done in cycle 2, flush variant
        // requests flush from cycle 2 and completes after the ack.
        seen1 = done_seen[1];
        fence = 1;
        tick();
        fence = 0;
        #1 chk("lat_busy0", busy[0], 1);
        chk("lat_done0_c1", done[0], 0);
        tick();
        #1 chk("lat_done0_c2", done[0], 1);
        chk("lat_flush1_c2", freq[1], 1);
        repeat (4) tick();
        flush_ack = 1;
        tick();
        flush_ack = 0;
        #1 chk("flush_done1", done[1], 1);
        repeat (2) tick();
        chk("flush_done_cnt1", done_seen[1] - seen1, 1);

        // Underflow: ack with nothing outstanding, then more traffic at zero.
        st_ack = 1;
        tick();
        chk("under_set", under[0], 1);
        tick();
        st_ack = 0;
        repeat (3) tick();
        chk("under_sticky", under[0], 1);
        chk("under_cnt", outst[0], 0);

        // Reset while the flush variant is in FLUSH: no completion afterwards.
        seen1 = done_seen[1];
        fence = 1;
        tick();
        fence = 0;
        tick();
        #1 chk("mid_flush_req", freq[1], 1);
        apply_reset();
        repeat (5) tick();
        chk("mid_no_done", done_seen[1] - seen1, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            st_req    = 1'($urandom_range(0, 1));
            st_ack    = ($urandom_range(0, 2) == 0);
            fence     = ($urandom_range(0, 11) == 0);
            flush_ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 599) == 0) apply_reset();
            tick();
        end
        idle_inputs();
        repeat (20) tick();
        flush_ack = 1;
        repeat (3) tick();
        flush_ack = 0;
        tick();

        chk("doneq0_empty", exp_q0.size(), 0);
        chk("doneq1_empty", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
